// File: rtl/cga_pkg.sv
// Shared I/O-window offsets, Tandy index numbers and wait-state encoding for the CGA register block.
package cga_pkg;

  localparam logic [3:0] OFS_CTRL     = 4'h8;
  localparam logic [3:0] OFS_COLOR    = 4'h9;
  localparam logic [3:0] OFS_STATUS   = 4'hA;
  localparam logic [3:0] OFS_LPEN_CLR = 4'hB;
  localparam logic [3:0] OFS_LPEN_SET = 4'hC;
  localparam logic [3:0] OFS_TDATA    = 4'hE;

  localparam int IDX_BORDER = 2;
  localparam int IDX_MODE   = 3;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_WAIT_A,
    WS_WAIT_B,
    WS_READY
  } wait_state_t;

endpackage

// File: rtl/cga_wait_gen.sv
// Holds CPU VRAM accesses off the ISA bus until the sequencer passes slot A then slot B.
// Latency: bus_rdy drops the cycle after the access is seen; rises the cycle after slot B.
// Backpressure: bus_rdy low is the only stall; a released strobe always returns to idle.
module cga_wait_gen
  import cga_pkg::*;
#(
  parameter bit         USE_BUS_WAIT = 1'b1,
  parameter logic [4:0] WAIT_SLOT_A  = 5'd17,
  parameter logic [4:0] WAIT_SLOT_B  = 5'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vram_cs,
  input  logic       mem_act,
  input  logic [4:0] clk_seq,
  output logic       bus_rdy
);

  wait_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= WS_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_rdy   = 1'b1;
    case (state)
      WS_IDLE: begin
        if (vram_cs && mem_act) state_nxt = WS_WAIT_A;
      end
      WS_WAIT_A: begin
        bus_rdy = !USE_BUS_WAIT;
        if (!mem_act)                    state_nxt = WS_IDLE;
        else if (clk_seq == WAIT_SLOT_A) state_nxt = WS_WAIT_B;
      end
      WS_WAIT_B: begin
        bus_rdy = !USE_BUS_WAIT;
        if (!mem_act)                    state_nxt = WS_IDLE;
        else if (clk_seq == WAIT_SLOT_B) state_nxt = WS_READY;
      end
      WS_READY: begin
        if (!mem_act) state_nxt = WS_IDLE;
      end
      default: state_nxt = WS_IDLE;
    endcase
  end

endmodule

// File: rtl/cga_bus_regs.sv
// ISA-side CGA/Tandy register file, status/light-pen latch and VRAM wait-state control.
// Latency: register writes land 3 clk after iow_l falls; reads are combinational.
// Backpressure: none on I/O; VRAM accesses are stalled through bus_rdy.
module cga_bus_regs
  import cga_pkg::*;
#(
  parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
  parameter int          IDX_BITS     = 5,
  parameter int          PAL_ENTRIES  = 16,
  parameter int          PAL_WIDTH    = 4,
  parameter bit          USE_BUS_WAIT = 1'b1,
  parameter logic [4:0]  WAIT_SLOT_A  = 5'd17,
  parameter logic [4:0]  WAIT_SLOT_B  = 5'd20,
  parameter logic [7:0]  CTRL_RESET   = 8'h29
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [14:0]                    bus_a,
  input  logic                           bus_ior_l,
  input  logic                           bus_iow_l,
  input  logic                           bus_memr_l,
  input  logic                           bus_memw_l,
  input  logic                           bus_aen,
  input  logic                           vram_cs,
  input  logic [7:0]                     bus_d,
  output logic [7:0]                     bus_out,
  output logic                           bus_dir,
  output logic                           bus_rdy,
  input  logic [4:0]                     clk_seq,
  input  logic                           vsync_l,
  input  logic                           display_enable,
  input  logic                           lpen_trig,
  output logic                           crtc_cs,
  input  logic [7:0]                     crtc_rd_data,
  output logic [7:0]                     control_reg,
  output logic [7:0]                     color_reg,
  output logic [3:0]                     border_col,
  output logic [4:0]                     mode_sel,
  output logic                           pal_wr,
  output logic [$clog2(PAL_ENTRIES)-1:0] pal_idx,
  output logic [PAL_WIDTH-1:0]           pal_data
);

  localparam int PAL_IW = $clog2(PAL_ENTRIES);

  logic [3:0]          ofs;
  logic                win_hit;
  logic                iow_s1, iow_s2, iow_s3;
  logic                wr_fire;
  logic [IDX_BITS-1:0] tandy_idx;
  logic [31:0]         idx_ext;
  logic                pal_hit;
  logic                lpen_q, lpen_latch, lpen_set, lpen_clr;
  logic [7:0]          status;
  logic                status_sel;

  assign ofs        = bus_a[3:0];
  assign win_hit    = (bus_a[14:4] == IO_BASE_ADDR[14:4]);
  assign status_sel = win_hit && (ofs == OFS_STATUS);
  assign crtc_cs    = win_hit && !ofs[3] && !bus_aen;

  // iow_s3 is the edge register: a write fires once on the synced falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      iow_s1 <= 1'b1;
      iow_s2 <= 1'b1;
      iow_s3 <= 1'b1;
    end else begin
      iow_s1 <= bus_iow_l;
      iow_s2 <= iow_s1;
      iow_s3 <= iow_s2;
    end
  end

  assign wr_fire  = iow_s3 && !iow_s2 && win_hit && !bus_aen;
  assign idx_ext  = 32'(tandy_idx);
  assign pal_hit  = (idx_ext >= 32'(PAL_ENTRIES)) && (idx_ext < 32'(2 * PAL_ENTRIES));
  assign lpen_set = (lpen_trig && !lpen_q) || (wr_fire && (ofs == OFS_LPEN_SET));
  assign lpen_clr = wr_fire && (ofs == OFS_LPEN_CLR);

  always_ff @(posedge clk) begin
    if (reset) begin
      control_reg <= CTRL_RESET;
      color_reg   <= '0;
      border_col  <= '0;
      mode_sel    <= '0;
      tandy_idx   <= '0;
      lpen_q      <= 1'b0;
      lpen_latch  <= 1'b0;
      pal_wr      <= 1'b0;
      pal_idx     <= '0;
      pal_data    <= '0;
    end else begin
      pal_wr <= 1'b0;
      lpen_q <= lpen_trig;
      if (wr_fire) begin
        case (ofs)
          OFS_CTRL:   control_reg <= bus_d;
          OFS_COLOR:  color_reg   <= bus_d;
          OFS_STATUS: tandy_idx   <= bus_d[IDX_BITS-1:0];
          OFS_TDATA: begin
            if (idx_ext == IDX_BORDER) begin
              border_col <= bus_d[3:0];
            end else if (idx_ext == IDX_MODE) begin
              mode_sel <= bus_d[4:0];
            end else if (pal_hit) begin
              pal_wr   <= 1'b1;
              pal_idx  <= PAL_IW'(idx_ext - 32'(PAL_ENTRIES));
              pal_data <= bus_d[PAL_WIDTH-1:0];
            end
          end
          default: ;
        endcase
      end
      // A set in the same cycle as a clear leaves the latch set.
      if (lpen_set)      lpen_latch <= 1'b1;
      else if (lpen_clr) lpen_latch <= 1'b0;
    end
  end

  assign status = {4'b1111, ~vsync_l, 1'b1, lpen_latch, ~display_enable};

  always_comb begin
    bus_out = 8'h00;
    if (status_sel)                       bus_out = status;
    else if (win_hit && !ofs[3] && ofs[0]) bus_out = crtc_rd_data;
  end

  assign bus_dir = (crtc_cs || status_sel) && !bus_ior_l && !bus_aen;

  cga_wait_gen #(
    .USE_BUS_WAIT (USE_BUS_WAIT),
    .WAIT_SLOT_A  (WAIT_SLOT_A),
    .WAIT_SLOT_B  (WAIT_SLOT_B)
  ) u_wait (
    .clk     (clk),
    .reset   (reset),
    .vram_cs (vram_cs),
    .mem_act (!bus_memr_l || !bus_memw_l),
    .clk_seq (clk_seq),
    .bus_rdy (bus_rdy)
  );

endmodule

// File: tb/tb_cga_bus_regs.sv
// Self-checking bench for cga_bus_regs: vector table, hand sequences, randomized writes and wait timing.
module tb_cga_bus_regs;

  localparam logic [10:0] WIN = 11'h03D;
  localparam int WSA = 17;
  localparam int WSB = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [14:0] bus_a;
  logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen, vram_cs;
  logic [7:0]  bus_d, crtc_rd_data;
  logic [4:0]  clk_seq;
  logic        vsync_l, display_enable, lpen_trig;

  logic [7:0]  bus_out, control_reg, color_reg;
  logic        bus_dir, bus_rdy, crtc_cs, pal_wr;
  logic [3:0]  border_col, pal_idx, pal_data;
  logic [4:0]  mode_sel;

  logic [7:0]  bus_out2, control_reg2, color_reg2;
  logic        bus_dir2, bus_rdy2, crtc_cs2, pal_wr2;
  logic [3:0]  border_col2, pal_idx2, pal_data2;
  logic [4:0]  mode_sel2;

  cga_bus_regs u_dut (
    .clk(clk), .reset(reset), .bus_a(bus_a), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
    .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_aen(bus_aen), .vram_cs(vram_cs),
    .bus_d(bus_d), .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy), .clk_seq(clk_seq),
    .vsync_l(vsync_l), .display_enable(display_enable), .lpen_trig(lpen_trig), .crtc_cs(crtc_cs),
    .crtc_rd_data(crtc_rd_data), .control_reg(control_reg), .color_reg(color_reg),
    .border_col(border_col), .mode_sel(mode_sel), .pal_wr(pal_wr), .pal_idx(pal_idx), .pal_data(pal_data)
  );

  cga_bus_regs #(.USE_BUS_WAIT(1'b0)) u_nowait (
    .clk(clk), .reset(reset), .bus_a(bus_a), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
    .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_aen(bus_aen), .vram_cs(vram_cs),
    .bus_d(bus_d), .bus_out(bus_out2), .bus_dir(bus_dir2), .bus_rdy(bus_rdy2), .clk_seq(clk_seq),
    .vsync_l(vsync_l), .display_enable(display_enable), .lpen_trig(lpen_trig), .crtc_cs(crtc_cs2),
    .crtc_rd_data(crtc_rd_data), .control_reg(control_reg2), .color_reg(color_reg2),
    .border_col(border_col2), .mode_sel(mode_sel2), .pal_wr(pal_wr2), .pal_idx(pal_idx2), .pal_data(pal_data2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int pal_cnt = 0;
  logic [3:0] pal_last_idx, pal_last_dat;

  // Transaction-level model of the register file.
  logic [7:0] m_ctrl = 8'h29, m_color = 8'h00;
  logic [3:0] m_border = 4'h0, m_pidx = 4'h0, m_pdat = 4'h0;
  logic [4:0] m_mode = 5'h00, m_idx = 5'h00;
  logic       m_lpen = 1'b0;
  bit         exp_pal;

  typedef struct {
    bit          rd;
    logic [14:0] a;
    logic [7:0]  d;
    logic        aen;
    logic [7:0]  e_ctrl, e_color;
    logic [3:0]  e_border;
    logic [4:0]  e_mode;
    int          e_npal;
    logic [3:0]  e_pidx, e_pdat;
    logic [7:0]  e_out;
    logic        e_dir, e_cs;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t wv(input logic [14:0] a, input logic [7:0] d, input logic aen,
                              input logic [7:0] c, input logic [7:0] col, input logic [3:0] b,
                              input logic [4:0] m, input int np, input logic [3:0] pi, input logic [3:0] pd);
    vec_t v;
    v = '{rd: 1'b0, a: a, d: d, aen: aen, e_ctrl: c, e_color: col, e_border: b, e_mode: m,
          e_npal: np, e_pidx: pi, e_pdat: pd, e_out: 8'h00, e_dir: 1'b0, e_cs: 1'b0};
    return v;
  endfunction

  function automatic vec_t rv(input logic [14:0] a, input logic aen, input logic [7:0] o,
                              input logic dir, input logic cs);
    vec_t v;
    v = '{rd: 1'b1, a: a, d: 8'h00, aen: aen, e_ctrl: 8'h00, e_color: 8'h00, e_border: 4'h0,
          e_mode: 5'h00, e_npal: 0, e_pidx: 4'h0, e_pdat: 4'h0, e_out: o, e_dir: dir, e_cs: cs};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clk_seq = clk_seq + 5'd1;
    if (pal_wr) begin
      pal_cnt++;
      pal_last_idx = pal_idx;
      pal_last_dat = pal_data;
    end
  endtask

  task automatic model_write(input logic [14:0] a, input logic [7:0] d, input logic aen, input bit trig);
    exp_pal = 1'b0;
    if (!aen && a[14:4] == WIN) begin
      case (a[3:0])
        4'h8: m_ctrl = d;
        4'h9: m_color = d;
        4'hA: m_idx = d[4:0];
        4'hB: m_lpen = 1'b0;
        4'hC: m_lpen = 1'b1;
        4'hE: begin
          if (m_idx == 5'd2) m_border = d[3:0];
          else if (m_idx == 5'd3) m_mode = d[4:0];
          else if (m_idx >= 5'd16) begin
            exp_pal = 1'b1;
            m_pidx  = 4'(m_idx - 5'd16);
            m_pdat  = d[3:0];
          end
        end
        default: ;
      endcase
    end
    if (trig) m_lpen = 1'b1;
  endtask

  // Full ISA write cycle; trig raises lpen_trig on the same clock the write takes effect.
  task automatic do_write(input logic [14:0] a, input logic [7:0] d, input logic aen, input bit trig,
                          output int npal);
    int p0;
    p0 = pal_cnt;
    bus_a = a; bus_d = d; bus_aen = aen; bus_iow_l = 1'b0;
    tick(); tick();
    if (trig) lpen_trig = 1'b1;
    tick();
    lpen_trig = 1'b0;
    tick();
    bus_iow_l = 1'b1;
    repeat (4) tick();
    bus_aen = 1'b0;
    model_write(a, d, aen, trig);
    npal = pal_cnt - p0;
  endtask

  task automatic read_chk(input string nm, input logic [14:0] a, input logic aen,
                          input logic [7:0] exp_out, input logic exp_dir);
    bus_a = a; bus_aen = aen; bus_ior_l = 1'b0;
    #1;
    chk({nm, "_out"}, bus_out, exp_out);
    chk({nm, "_dir"}, bus_dir, exp_dir);
    tick();
    bus_ior_l = 1'b1; bus_aen = 1'b0;
    tick();
  endtask

  task automatic wait_access(input string nm, input logic [4:0] s0, input bit use_w);
    int lowc, expc;
    bit nw_low;
    clk_seq = s0; vram_cs = 1'b1;
    if (use_w) bus_memw_l = 1'b0; else bus_memr_l = 1'b0;
    tick();
    chk({nm, "_fall"}, bus_rdy, 1'b0);
    lowc = 0; nw_low = 1'b0;
    while (bus_rdy == 1'b0 && lowc < 80) begin
      lowc++;
      if (!bus_rdy2) nw_low = 1'b1;
      tick();
    end
    expc = ((WSA - int'(s0) + 31) % 32) + 1 + ((WSB - WSA + 31) % 32) + 1;
    chk({nm, "_lowcycles"}, lowc, expc);
    chk({nm, "_nowait_rdy"}, nw_low, 1'b0);
    tick();
    chk({nm, "_ready_hold"}, bus_rdy, 1'b1);
    bus_memr_l = 1'b1; bus_memw_l = 1'b1;
    tick();
    chk({nm, "_release"}, bus_rdy, 1'b1);
    vram_cs = 1'b0;
    tick();
  endtask

  initial begin
    int np;
    logic [14:0] ra;
    logic [7:0]  rd8;
    logic        raen;
    int          r;

    reset = 1'b1; bus_a = '0; bus_d = '0; bus_ior_l = 1'b1; bus_iow_l = 1'b1;
    bus_memr_l = 1'b1; bus_memw_l = 1'b1; bus_aen = 1'b0; vram_cs = 1'b0; clk_seq = '0;
    vsync_l = 1'b1; display_enable = 1'b0; lpen_trig = 1'b0; crtc_rd_data = 8'h5A;
    pal_last_idx = '0; pal_last_dat = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_ctrl", control_reg, 8'h29);
    chk("rst_color", color_reg, 8'h00);
    chk("rst_border", border_col, 4'h0);
    chk("rst_mode", mode_sel, 5'h00);
    chk("rst_palwr", pal_wr, 1'b0);
    chk("rst_rdy", bus_rdy, 1'b1);
    chk("rst_rdy_nowait", bus_rdy2, 1'b1);
    bus_a = 15'h3DA; #1;
    chk("rst_status", bus_out, 8'hF5);
    chk("rst_dir", bus_dir, 1'b0);

    // Write latency: lands on exactly the third clock after iow_l falls.
    bus_a = 15'h3D8; bus_d = 8'h1A; bus_iow_l = 1'b0;
    tick(); chk("lat_c1", control_reg, 8'h29);
    tick(); chk("lat_c2", control_reg, 8'h29);
    tick(); chk("lat_c3", control_reg, 8'h1A);
    chk("lat_color", color_reg, 8'h00);
    tick(); bus_iow_l = 1'b1;
    repeat (4) tick();
    model_write(15'h3D8, 8'h1A, 1'b0, 1'b0);

    vecs.push_back(wv(15'h3D9, 8'h15, 0, 8'h1A, 8'h15, 4'h0, 5'h00, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DA, 8'h13, 0, 8'h1A, 8'h15, 4'h0, 5'h00, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DE, 8'h07, 0, 8'h1A, 8'h15, 4'h0, 5'h00, 1, 4'h3, 4'h7));
    vecs.push_back(wv(15'h3DA, 8'h03, 0, 8'h1A, 8'h15, 4'h0, 5'h00, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DE, 8'h1F, 0, 8'h1A, 8'h15, 4'h0, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DA, 8'h02, 0, 8'h1A, 8'h15, 4'h0, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DE, 8'hAB, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3D9, 8'hFF, 1, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DA, 8'h05, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DE, 8'h44, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DA, 8'h1F, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DE, 8'h3C, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 1, 4'hF, 4'hC));
    vecs.push_back(wv(15'h3DA, 8'h10, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DE, 8'h09, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 1, 4'h0, 4'h9));
    vecs.push_back(wv(15'h3DA, 8'h0F, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DE, 8'h66, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3D0, 8'h55, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3E8, 8'h77, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3DF, 8'h99, 0, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(wv(15'h3D8, 8'h00, 1, 8'h1A, 8'h15, 4'hB, 5'h1F, 0, 4'h0, 4'h0));
    vecs.push_back(rv(15'h3DA, 0, 8'hF5, 1, 0));
    vecs.push_back(rv(15'h3DA, 1, 8'hF5, 0, 0));
    vecs.push_back(rv(15'h3D1, 0, 8'h5A, 1, 1));
    vecs.push_back(rv(15'h3D7, 0, 8'h5A, 1, 1));
    vecs.push_back(rv(15'h3D0, 0, 8'h00, 1, 1));
    vecs.push_back(rv(15'h3D8, 0, 8'h00, 0, 0));
    vecs.push_back(rv(15'h3D9, 0, 8'h00, 0, 0));
    vecs.push_back(rv(15'h3E1, 0, 8'h00, 0, 0));
    vecs.push_back(rv(15'h3D3, 1, 8'h5A, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rd) begin
        bus_a = vecs[i].a; bus_aen = vecs[i].aen; bus_ior_l = 1'b0;
        #1;
        chk($sformatf("v%0d_out", i), bus_out, vecs[i].e_out);
        chk($sformatf("v%0d_dir", i), bus_dir, vecs[i].e_dir);
        chk($sformatf("v%0d_cs", i), crtc_cs, vecs[i].e_cs);
        tick();
        bus_ior_l = 1'b1; bus_aen = 1'b0;
        tick();
      end else begin
        do_write(vecs[i].a, vecs[i].d, vecs[i].aen, 1'b0, np);
        chk($sformatf("v%0d_ctrl", i), control_reg, vecs[i].e_ctrl);
        chk($sformatf("v%0d_color", i), color_reg, vecs[i].e_color);
        chk($sformatf("v%0d_border", i), border_col, vecs[i].e_border);
        chk($sformatf("v%0d_mode", i), mode_sel, vecs[i].e_mode);
        chk($sformatf("v%0d_palcnt", i), np, vecs[i].e_npal);
        if (vecs[i].e_npal == 1) begin
          chk($sformatf("v%0d_palidx", i), pal_last_idx, vecs[i].e_pidx);
          chk($sformatf("v%0d_paldat", i), pal_last_dat, vecs[i].e_pdat);
        end
      end
    end

    // Light-pen latch: trigger edge, explicit clear/set, and set winning over clear.
    vsync_l = 1'b0; display_enable = 1'b1;
    lpen_trig = 1'b1; tick(); lpen_trig = 1'b0; tick();
    m_lpen = 1'b1;
    read_chk("lp_trig", 15'h3DA, 1'b0, 8'hFE, 1'b1);
    do_write(15'h3DB, 8'h00, 1'b0, 1'b0, np);
    read_chk("lp_clr", 15'h3DA, 1'b0, 8'hFC, 1'b1);
    do_write(15'h3DC, 8'h00, 1'b0, 1'b0, np);
    read_chk("lp_set", 15'h3DA, 1'b0, 8'hFE, 1'b1);
    do_write(15'h3DB, 8'h00, 1'b0, 1'b1, np);
    read_chk("lp_setwins", 15'h3DA, 1'b0, 8'hFE, 1'b1);
    do_write(15'h3DB, 8'h00, 1'b0, 1'b0, np);
    read_chk("lp_clr2", 15'h3DA, 1'b0, 8'hFC, 1'b1);

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0)      ra = {11'h03E, 4'($urandom_range(0, 15))};
      else if (r <= 3) ra = {WIN, 4'hA};
      else if (r <= 6) ra = {WIN, 4'hE};
      else             ra = {WIN, 4'($urandom_range(0, 15))};
      rd8  = 8'($urandom_range(0, 255));
      raen = ($urandom_range(0, 7) == 0);
      do_write(ra, rd8, raen, 1'b0, np);
      chk($sformatf("r%0d_ctrl", i), control_reg, m_ctrl);
      chk($sformatf("r%0d_color", i), color_reg, m_color);
      chk($sformatf("r%0d_border", i), border_col, m_border);
      chk($sformatf("r%0d_mode", i), mode_sel, m_mode);
      chk($sformatf("r%0d_palcnt", i), np, exp_pal ? 1 : 0);
      if (exp_pal) begin
        chk($sformatf("r%0d_palidx", i), pal_last_idx, m_pidx);
        chk($sformatf("r%0d_paldat", i), pal_last_dat, m_pdat);
      end
      vsync_l = 1'($urandom_range(0, 1));
      display_enable = 1'($urandom_range(0, 1));
      read_chk($sformatf("r%0d_status", i), 15'h3DA, 1'b0,
               {4'hF, ~vsync_l, 1'b1, m_lpen, ~display_enable}, 1'b1);
    end

    // Wait-state generator.
    wait_access("w_s3", 5'd3, 1'b0);
    wait_access("w_slotA", 5'd17, 1'b1);
    wait_access("w_s20", 5'd20, 1'b0);
    for (int i = 0; i < 8; i++)
      wait_access($sformatf("w_rnd%0d", i), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

    clk_seq = 5'd3; vram_cs = 1'b1; bus_memr_l = 1'b0;
    tick(); chk("rel_low", bus_rdy, 1'b0);
    repeat (4) tick();
    bus_memr_l = 1'b1;
    tick(); chk("rel_idle", bus_rdy, 1'b1);
    tick(); chk("rel_idle2", bus_rdy, 1'b1);

    vram_cs = 1'b0; bus_memw_l = 1'b0;
    tick(); tick(); chk("nocs_rdy", bus_rdy, 1'b1);
    bus_memw_l = 1'b1; tick();

    // Reset while in WAIT_B, strobe still held through reset.
    clk_seq = 5'd16; vram_cs = 1'b1; bus_memr_l = 1'b0;
    tick(); tick();
    chk("wb_low", bus_rdy, 1'b0);
    reset = 1'b1;
    tick();
    chk("wb_rst_rdy", bus_rdy, 1'b1);
    chk("wb_rst_ctrl", control_reg, 8'h29);
    reset = 1'b0;
    tick();
    chk("wb_restart", bus_rdy, 1'b0);
    bus_memr_l = 1'b1;
    tick();
    chk("wb_release", bus_rdy, 1'b1);
    vram_cs = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
